// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: response routing, lock ownership, port indices.
// No logic; no latency.
// No backpressure of its own.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam int CPU_PORT = 0;
    localparam int DMA_PORT = 1;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_CPU  = 2'd1,
        RESP_DMA  = 2'd2
    } resp_sel_e;

    typedef enum logic {
        OWN_NONE = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Counts consecutive denied DMA request cycles and raises force_dma at the limit.
// force_dma is a decode of the registered count (0-cycle from state, 1-cycle from a denial).
// Frozen while freeze_i is high; cleared when DMA is granted or stops requesting.
module dmem_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dma_req_i,
    input  logic dma_gnt_i,
    input  logic freeze_i,
    output logic force_dma_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (freeze_i) begin
            cnt_d = cnt_q;
        end else if (!dma_req_i || dma_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_dma_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU priority, DMA) arbiter for a single-port memory; optional CPU lock via DMEM_ARB_LOCK_EN.
// Grant is combinational in the access cycle; read data returns registered one cycle later.
// Loser is held off by gnt=0 and must keep req and payload stable until granted.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              cpu_lock,
`endif
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in_data,
    output logic              mem_w_en,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_out_data
);

    logic [1:0]        win;
    logic              force_dma;
    logic              lock_block;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    resp_sel_e         resp_sel_q, resp_sel_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

`ifdef DMEM_ARB_LOCK_EN
    owner_e owner_q, owner_d;

    always_comb begin
        owner_d = owner_q;
        if (win[CPU_PORT]) begin
            owner_d = cpu_lock ? OWN_CPU : OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign lock_block = (owner_q == OWN_CPU);
`else
    assign lock_block = 1'b0;
`endif

    // Grants are gated by reset_n so no memory access can slip out while reset is asserted.
    always_comb begin
        win = '0;
        if (reset_n) begin
            if (dma_req && !lock_block && (!cpu_req || force_dma)) begin
                win[DMA_PORT] = 1'b1;
            end else if (cpu_req) begin
                win[CPU_PORT] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (win[CPU_PORT]) begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end else if (win[DMA_PORT]) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    assign cpu_gnt     = win[CPU_PORT];
    assign dma_gnt     = win[DMA_PORT];
    assign mem_address = sel_addr;
    assign mem_in_data = sel_wdata;
    assign mem_w_en    = (|win) & sel_we;
    assign mem_en      = (|win) & ~sel_we;

    dmem_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .dma_req_i   (dma_req),
        .dma_gnt_i   (win[DMA_PORT]),
        .freeze_i    (lock_block),
        .force_dma_o (force_dma)
    );

    always_comb begin
        resp_sel_d  = RESP_NONE;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        if (win[CPU_PORT] && !cpu_we) begin
            resp_sel_d  = RESP_CPU;
            cpu_rdata_d = mem_out_data;
        end else if (win[DMA_PORT] && !dma_we) begin
            resp_sel_d  = RESP_DMA;
            dma_rdata_d = mem_out_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_sel_q  <= RESP_NONE;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            resp_sel_q  <= resp_sel_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign cpu_rvalid = (resp_sel_q == RESP_CPU);
    assign dma_rvalid = (resp_sel_q == RESP_DMA);
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table with a read-data scoreboard, plus reset-mid-read sequence.
// Lock rows are added when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

    logic       clk;
    logic       reset_n;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
`ifdef DMEM_ARB_LOCK_EN
    logic       cpu_lock;
`endif
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dma_req, dma_we;
    logic [7:0] dma_addr, dma_wdata;
    logic       dma_gnt, dma_rvalid;
    logic [7:0] dma_rdata;
    logic [7:0] mem_address, mem_in_data, mem_out_data;
    logic       mem_w_en, mem_en;

    dmem_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .cpu_lock     (cpu_lock),
`endif
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_gnt      (dma_gnt),
        .dma_rvalid   (dma_rvalid),
        .dma_rdata    (dma_rdata),
        .mem_address  (mem_address),
        .mem_in_data  (mem_in_data),
        .mem_w_en     (mem_w_en),
        .mem_en       (mem_en),
        .mem_out_data (mem_out_data)
    );

    // Physical memory driven by the DUT, and an independent reference updated from expected grants.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_w_en) mem[mem_address] <= mem_in_data;
    end
    assign mem_out_data = mem[mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cr, cw, lk;
        logic [7:0] ca, cd;
        logic       dr, dw;
        logic [7:0] da, dd;
        logic       ecg, edg;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] cpu_q[$];
    logic [7:0] dma_q[$];
    int         n_pass = 0;
    int         n_chk  = 0;
    logic       exp_crv = 1'b0, exp_drv = 1'b0;
    logic       nxt_crv, nxt_drv;
    logic [7:0] last_c = 8'h00, last_d = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic add(input logic cr, input logic cw, input logic lk, input logic [7:0] ca,
                       input logic [7:0] cd, input logic dr, input logic dw, input logic [7:0] da,
                       input logic [7:0] dd, input logic ecg, input logic edg);
        vec_t v;
        v.cr = cr; v.cw = cw; v.lk = lk; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.ecg = ecg; v.edg = edg;
        tbl.push_back(v);
    endtask

    task automatic check_resp();
        chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_crv});
        if (exp_crv) last_c = cpu_q.pop_front();
        chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, last_c});
        chk("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, exp_drv});
        if (exp_drv) last_d = dma_q.pop_front();
        chk("dma_rdata", {24'd0, dma_rdata}, {24'd0, last_d});
    endtask

    initial begin
        vec_t       v;
        logic       ew, any;
        logic [7:0] ea, ed;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[8'h05]     = 8'h3C;
        ref_mem[8'h05] = 8'h3C;

        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
`ifdef DMEM_ARB_LOCK_EN
        cpu_lock = 0;
`endif

        // cr cw lk  ca     cd     dr dw  da     dd    ecg edg
        add(1, 1, 0, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 0, 8'h20, 8'h11, 1, 1, 8'h20, 8'h22, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h22, 0, 1);
        add(1, 0, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        for (int k = 0; k < 4; k++)
            add(1, 0, 0, 8'h10 + 8'(k), 8'h00, 1, 0, 8'h05, 8'h00, 1, 0);
        add(1, 0, 0, 8'h14, 8'h00, 1, 0, 8'h05, 8'h00, 0, 1);
        add(1, 0, 0, 8'h14, 8'h00, 1, 0, 8'h05, 8'h00, 1, 0);
        add(1, 0, 0, 8'h15, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h80 + 8'(k), 8'(k), 0, 1);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h77, 0, 1);
        add(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 0, 1);
        add(1, 1, 0, 8'h51, 8'hE1, 1, 0, 8'h50, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
`ifdef DMEM_ARB_LOCK_EN
        add(1, 0, 1, 8'h30, 8'h00, 1, 1, 8'h31, 8'h99, 1, 0);
        for (int k = 0; k < 10; k++)
            add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h31, 8'h99, 0, 0);
        add(1, 1, 0, 8'h30, 8'h5A, 1, 1, 8'h31, 8'h99, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h31, 8'h99, 0, 1);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_w_en", {31'd0, mem_w_en}, 32'd0);
        check_resp();
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
            dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
`ifdef DMEM_ARB_LOCK_EN
            cpu_lock = v.lk;
`endif
            @(negedge clk);
            check_resp();
            chk($sformatf("cpu_gnt[%0d]", i), {31'd0, cpu_gnt}, {31'd0, v.ecg});
            chk($sformatf("dma_gnt[%0d]", i), {31'd0, dma_gnt}, {31'd0, v.edg});
            any = v.ecg | v.edg;
            ew  = v.ecg ? v.cw : (v.edg ? v.dw : 1'b0);
            ea  = v.ecg ? v.ca : (v.edg ? v.da : 8'h00);
            ed  = v.ecg ? v.cd : (v.edg ? v.dd : 8'h00);
            chk($sformatf("mem_address[%0d]", i), {24'd0, mem_address}, {24'd0, ea});
            chk($sformatf("mem_in_data[%0d]", i), {24'd0, mem_in_data}, {24'd0, ed});
            chk($sformatf("mem_w_en[%0d]", i), {31'd0, mem_w_en}, {31'd0, any & ew});
            chk($sformatf("mem_en[%0d]", i), {31'd0, mem_en}, {31'd0, any & ~ew});
            nxt_crv = 1'b0;
            nxt_drv = 1'b0;
            if (any && ew) begin
                ref_mem[ea] = ed;
            end else if (any) begin
                if (v.ecg) begin cpu_q.push_back(ref_mem[ea]); nxt_crv = 1'b1; end
                else begin dma_q.push_back(ref_mem[ea]); nxt_drv = 1'b1; end
            end
            @(posedge clk); #1;
            exp_crv = nxt_crv;
            exp_drv = nxt_drv;
        end

        // Reset asserted inside the grant cycle of a CPU read.
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; dma_req = 0;
        #1 chk("rmr_gnt_before", {31'd0, cpu_gnt}, 32'd1);
        #1 reset_n = 1'b0;
        #1 chk("rmr_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rmr_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        @(posedge clk); #1;
        cpu_req = 0;
        reset_n = 1'b1;
        last_c = 8'h00;
        last_d = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_resp();
            @(posedge clk); #1;
        end

        for (int k = 0; k < 8; k++)
            chk($sformatf("burst_mem[%0d]", k), {24'd0, mem[8'h80 + k]}, k);
        chk("same_addr_mem", {24'd0, mem[8'h20]}, 32'h22);
        chk("raw_mem", {24'd0, mem[8'h40]}, 32'h77);
        chk("cpu_w_mem", {24'd0, mem[8'h10]}, 32'hA5);
`ifdef DMEM_ARB_LOCK_EN
        chk("lock_mem30", {24'd0, mem[8'h30]}, 32'h5A);
        chk("lock_mem31", {24'd0, mem[8'h31]}, 32'h99);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
